// File: rtl/x_sram_pkg.sv
// Shared constants and types for the 23K640 serial SRAM SPI master.
package x_sram_pkg;

   localparam logic [7:0] SRAM_OP_READ    = 8'h03;
   localparam logic [7:0] SRAM_OP_WRITE   = 8'h02;
   localparam int         SRAM_FRAME_BITS = 32;

   typedef enum logic [1:0] {
      HOLD,
      IDLE,
      SHIFT
   } t_sram_state;

endpackage

// File: rtl/x_sck_gen.sv
// SPI mode-0 clock generator: divides i_clk into SCK half-periods and counts
// completed SCK periods, wrapping at the end of a frame.
module x_sck_gen
   import x_sram_pkg::*;
#(
   parameter int p_clk_div = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   output logic       o_sck,
   output logic       o_rise,
   output logic       o_fall,
   output logic [5:0] o_period
);

   localparam int DW = (p_clk_div > 1) ? $clog2(p_clk_div) : 1;

   logic [DW-1:0] div_cnt;
   logic          half_done;

   // Strobes flag the i_clk edge on which SCK is about to change.
   assign half_done = i_en && (div_cnt == DW'(p_clk_div - 1));
   assign o_rise    = half_done && !o_sck;
   assign o_fall    = half_done && o_sck;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_cnt  <= '0;
         o_sck    <= 1'b0;
         o_period <= '0;
      end else if (!i_en) begin
         div_cnt  <= '0;
         o_sck    <= 1'b0;
         o_period <= '0;
      end else if (half_done) begin
         div_cnt <= '0;
         o_sck   <= ~o_sck;
         if (o_sck) begin
            if (o_period == 6'(SRAM_FRAME_BITS - 1))
               o_period <= '0;
            else
               o_period <= o_period + 6'd1;
         end
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

endmodule

// File: rtl/x_sram_spi.sv
// Per-context SPI master for one 23K640 SRAM: takes one byte read/write request,
// sends instruction + address + data in mode 0, and returns read data as a pulse.
module x_sram_spi
   import x_sram_pkg::*;
#(
   parameter int p_clk_div = 2,
   parameter int p_cs_hold = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_accept,
   input  logic        i_rd_n_wr,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_wdata,
   output logic        o_ready,
   output logic [7:0]  o_rdata,
   output logic        o_cs_n,
   output logic        o_sck,
   output logic        o_si,
   input  logic        i_so
);

   localparam int HW = $clog2(p_cs_hold + 1);

   t_sram_state state, next_state;
   logic [HW-1:0]              hold_cnt;
   logic [SRAM_FRAME_BITS-1:0] frame;
   logic                       is_read;
   logic [7:0]                 rx;
   logic                       sck_rise, sck_fall;
   logic [5:0]                 period;
   logic                       take, last_fall;

   x_sck_gen #(.p_clk_div(p_clk_div)) u_sck_gen (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (state == SHIFT),
      .o_sck    (o_sck),
      .o_rise   (sck_rise),
      .o_fall   (sck_fall),
      .o_period (period)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= HOLD;
      else
         state <= next_state;
   end

   // CS and SI are decoded from state so an asynchronous reset drops them at once.
   always_comb begin
      next_state = state;
      o_accept   = 1'b0;
      o_cs_n     = 1'b1;
      o_si       = 1'b0;
      take       = 1'b0;
      last_fall  = 1'b0;
      case (state)
         HOLD: begin
            if (hold_cnt == HW'(1))
               next_state = IDLE;
         end
         IDLE: begin
            o_accept = 1'b1;
            if (i_valid) begin
               take       = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            o_cs_n = 1'b0;
            o_si   = frame[SRAM_FRAME_BITS-1];
            if (sck_fall && period == 6'(SRAM_FRAME_BITS - 1)) begin
               last_fall  = 1'b1;
               next_state = HOLD;
            end
         end
         default: next_state = HOLD;
      endcase
   end

   // Data byte arrives during periods 25..32, i.e. period indices 24..31.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_cnt <= HW'(p_cs_hold);
         frame    <= '0;
         is_read  <= 1'b0;
         rx       <= '0;
         o_ready  <= 1'b0;
         o_rdata  <= '0;
      end else begin
         o_ready <= 1'b0;
         if (state == HOLD)
            hold_cnt <= hold_cnt - HW'(1);
         if (take) begin
            frame   <= {(i_rd_n_wr ? SRAM_OP_READ : SRAM_OP_WRITE), i_addr,
                        (i_rd_n_wr ? 8'h00 : i_wdata)};
            is_read <= i_rd_n_wr;
         end else if (sck_fall) begin
            frame <= {frame[SRAM_FRAME_BITS-2:0], 1'b0};
         end
         if (sck_rise && period[5:3] == 3'b011)
            rx <= {rx[6:0], i_so};
         if (last_fall) begin
            hold_cnt <= HW'(p_cs_hold);
            if (is_read) begin
               o_ready <= 1'b1;
               o_rdata <= rx;
            end
         end
      end
   end

endmodule

// File: tb/tb_x_sram_spi.sv
// Directed bench for x_sram_spi: a default-parameter instance with an SRAM model,
// plus a fast instance (p_clk_div=1, p_cs_hold=3) for timing checks.
module tb_x_sram_spi;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        valid_a = 1'b0, rd_a = 1'b0, so_a = 1'b0;
   logic [15:0] addr_a = '0;
   logic [7:0]  wdata_a = '0;
   logic        accept_a, ready_a, cs_a, sck_a, si_a;
   logic [7:0]  rdata_a;

   logic        valid_b = 1'b0, rd_b = 1'b0, so_b = 1'b1;
   logic [15:0] addr_b = '0;
   logic [7:0]  wdata_b = '0;
   logic        accept_b, ready_b, cs_b, sck_b, si_b;
   logic [7:0]  rdata_b;

   x_sram_spi #(.p_clk_div(2), .p_cs_hold(1)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_a), .o_accept(accept_a),
      .i_rd_n_wr(rd_a), .i_addr(addr_a), .i_wdata(wdata_a), .o_ready(ready_a),
      .o_rdata(rdata_a), .o_cs_n(cs_a), .o_sck(sck_a), .o_si(si_a), .i_so(so_a)
   );

   x_sram_spi #(.p_clk_div(1), .p_cs_hold(3)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_b), .o_accept(accept_b),
      .i_rd_n_wr(rd_b), .i_addr(addr_b), .i_wdata(wdata_b), .o_ready(ready_b),
      .o_rdata(rdata_b), .o_cs_n(cs_b), .o_sck(sck_b), .o_si(si_b), .i_so(so_b)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Monitor state for instance A (cycle numbers: cycle k follows clock edge k-1).
   logic        prev_cs_a = 1'b1, prev_sck_a = 1'b0;
   logic [31:0] si_cap = '0, last_frame = '0;
   logic [7:0]  cur_byte = '0, rd_last = '0, rd_prev = '0;
   logic [7:0]  byte_q[$];
   int rises_a = 0, hs_count = 0, hs_cyc = 0, hs_cyc_prev = 0;
   int low_len = 0, high_len = 0, last_low_len = 0, last_high_len = 0;
   int frames_done = 0, ready_cnt = 0, ready_cyc = 0;

   // Monitor state for instance B.
   logic       prev_cs_b = 1'b1, prev_sck_b = 1'b0, prev_acc_b = 1'b0;
   logic [7:0] rd_b_last = '0;
   int hs_b_count = 0, hs_b_cyc = 0, low_b = 0, last_low_b = 0, toggles_b = 0;
   int ready_b_cnt = 0, ready_b_cyc = 0, acc_b_cnt = 0, acc_b_cyc = 0;

   // Observes both DUTs 1 time unit after each rising edge; also plays the SRAM for A,
   // changing SO after SCK falls and serving one queued byte per frame.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (prev_cs_a && !cs_a) begin
         hs_count++;
         hs_cyc_prev   = hs_cyc;
         hs_cyc        = cyc - 1;
         last_high_len = high_len;
         si_cap        = '0;
         rises_a       = 0;
         low_len       = 0;
         so_a          = 1'b0;
         if (byte_q.size() > 0) cur_byte = byte_q.pop_front();
         else                   cur_byte = 8'h00;
      end
      if (!prev_cs_a && cs_a) begin
         last_low_len = low_len;
         last_frame   = si_cap;
         frames_done++;
         high_len = 0;
      end
      if (cs_a) high_len++;
      else      low_len++;
      if (!cs_a && sck_a && !prev_sck_a) begin
         si_cap = {si_cap[30:0], si_a};
         rises_a++;
      end
      if (!cs_a && !sck_a && prev_sck_a)
         so_a = (rises_a >= 24 && rises_a < 32) ? cur_byte[31 - rises_a] : 1'b0;
      if (ready_a) begin
         ready_cnt++;
         ready_cyc = cyc;
         rd_prev   = rd_last;
         rd_last   = rdata_a;
      end
      prev_cs_a  = cs_a;
      prev_sck_a = sck_a;

      if (prev_cs_b && !cs_b) begin
         hs_b_count++;
         hs_b_cyc  = cyc - 1;
         low_b     = 0;
         toggles_b = 0;
      end
      if (!prev_cs_b && cs_b) last_low_b = low_b;
      if (!cs_b) low_b++;
      if (!cs_b && !prev_cs_b && sck_b != prev_sck_b) toggles_b++;
      if (ready_b) begin
         ready_b_cnt++;
         ready_b_cyc = cyc;
         rd_b_last   = rdata_b;
      end
      if (accept_b && !prev_acc_b) begin
         acc_b_cnt++;
         acc_b_cyc = cyc;
      end
      prev_cs_b  = cs_b;
      prev_sck_b = sck_b;
      prev_acc_b = accept_b;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Presents one request to instance A and drops i_valid once it is taken.
   task automatic applyStimulus(input logic rd, input logic [15:0] addr,
                                input logic [7:0] data);
      int base = hs_count;
      @(negedge clk);
      valid_a = 1'b1;
      rd_a    = rd;
      addr_a  = addr;
      wdata_a = data;
      for (int i = 0; i < 400 && hs_count == base; i++) @(negedge clk);
      valid_a = 1'b0;
      checkOutput("handshake_a", hs_count - base, 1);
   endtask

   task automatic waitReadyA(input int target);
      for (int i = 0; i < 400 && ready_cnt < target; i++) @(negedge clk);
      checkOutput("ready_wait_a", ready_cnt, target);
   endtask

   task automatic waitFrameA(input int target);
      for (int i = 0; i < 400 && frames_done < target; i++) @(negedge clk);
      checkOutput("frame_wait_a", frames_done, target);
   endtask

   initial begin
      int base_hs, base_rdy, base_fr;

      // Reset values and hold-off after release.
      #2;
      checkOutput("rst_accept", accept_a, 0);
      checkOutput("rst_ready", ready_a, 0);
      checkOutput("rst_rdata", rdata_a, 8'h00);
      checkOutput("rst_cs_n", cs_a, 1);
      checkOutput("rst_sck", sck_a, 0);
      checkOutput("rst_si", si_a, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 checkOutput("rel_accept_low", accept_a, 0);
      @(posedge clk);
      #2 checkOutput("rel_accept_high", accept_a, 1);

      // Write 0x1234 <= 0xA5.
      base_fr = frames_done;
      applyStimulus(1'b0, 16'h1234, 8'hA5);
      waitFrameA(base_fr + 1);
      checkOutput("wr_frame", last_frame, 32'h021234A5);
      checkOutput("wr_cs_low", last_low_len, 128);
      repeat (5) @(negedge clk);
      checkOutput("wr_no_ready", ready_cnt, 0);

      // Read 0x0010 with the SRAM returning 0x5A.
      byte_q.push_back(8'h5A);
      applyStimulus(1'b1, 16'h0010, 8'hFF);
      waitReadyA(1);
      checkOutput("rd_frame", last_frame, 32'h03001000);
      checkOutput("rd_ready_lat", ready_cyc - hs_cyc, 129);
      checkOutput("rd_data", rdata_a, 8'h5A);
      @(negedge clk);
      checkOutput("rd_ready_pulse", ready_a, 0);
      repeat (5) @(negedge clk);
      checkOutput("rd_data_hold", rdata_a, 8'h5A);

      // Two reads back-to-back with i_valid held; CS high = HOLD cycle + accept cycle.
      byte_q.push_back(8'hC3);
      byte_q.push_back(8'h3C);
      base_hs  = hs_count;
      base_rdy = ready_cnt;
      @(negedge clk);
      valid_a = 1'b1;
      rd_a    = 1'b1;
      addr_a  = 16'h0100;
      for (int i = 0; i < 600 && hs_count < base_hs + 2; i++) @(negedge clk);
      valid_a = 1'b0;
      waitReadyA(base_rdy + 2);
      checkOutput("b2b_hs_gap", hs_cyc - hs_cyc_prev, 130);
      checkOutput("b2b_cs_high", last_high_len, 2);
      checkOutput("b2b_rd_first", rd_prev, 8'hC3);
      checkOutput("b2b_rd_second", rd_last, 8'h3C);
      repeat (5) @(negedge clk);
      checkOutput("b2b_hs_count", hs_count - base_hs, 2);

      // Request fields wiggle during SHIFT: no new handshake, frame unaffected.
      base_hs  = hs_count;
      base_fr  = frames_done;
      base_rdy = ready_cnt;
      @(negedge clk);
      valid_a = 1'b1;
      rd_a    = 1'b0;
      addr_a  = 16'h0F0F;
      wdata_a = 8'h77;
      for (int i = 0; i < 400 && hs_count == base_hs; i++) @(negedge clk);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         addr_a  = addr_a + 16'h1111;
         wdata_a = ~wdata_a;
         rd_a    = ~rd_a;
      end
      valid_a = 1'b0;
      rd_a    = 1'b0;
      waitFrameA(base_fr + 1);
      checkOutput("shift_frame", last_frame, 32'h020F0F77);
      repeat (5) @(negedge clk);
      checkOutput("shift_hs_count", hs_count - base_hs, 1);
      checkOutput("shift_no_ready", ready_cnt, base_rdy);

      // Fast instance: SCK every cycle, CS low 64, ready T+65, accept T+68.
      base_hs = hs_b_count;
      base_rdy = acc_b_cnt;
      @(negedge clk);
      valid_b = 1'b1;
      rd_b    = 1'b1;
      addr_b  = 16'h0042;
      for (int i = 0; i < 200 && hs_b_count == base_hs; i++) @(negedge clk);
      valid_b = 1'b0;
      for (int i = 0; i < 200 && acc_b_cnt == base_rdy; i++) @(negedge clk);
      checkOutput("b_accept_seen", acc_b_cnt - base_rdy, 1);
      checkOutput("b_cs_low", last_low_b, 64);
      checkOutput("b_sck_toggles", toggles_b, 63);
      checkOutput("b_ready_lat", ready_b_cyc - hs_b_cyc, 65);
      checkOutput("b_accept_lat", acc_b_cyc - hs_b_cyc, 68);
      checkOutput("b_ready_count", ready_b_cnt, 1);
      checkOutput("b_rdata", rd_b_last, 8'hFF);

      // Reset during SCK period 10 of a read.
      byte_q.push_back(8'h99);
      base_rdy = ready_cnt;
      applyStimulus(1'b1, 16'h0200, 8'h00);
      for (int i = 0; i < 400 && rises_a < 10; i++) @(negedge clk);
      checkOutput("mid_rises", rises_a, 10);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid_cs_n", cs_a, 1);
      checkOutput("mid_sck", sck_a, 0);
      checkOutput("mid_si", si_a, 0);
      checkOutput("mid_accept", accept_a, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 checkOutput("mid_rel_accept_low", accept_a, 0);
      @(posedge clk);
      #2 checkOutput("mid_rel_accept_high", accept_a, 1);
      checkOutput("mid_no_ready", ready_cnt, base_rdy);
      byte_q.push_back(8'h81);
      applyStimulus(1'b1, 16'h1FFF, 8'h00);
      waitReadyA(base_rdy + 1);
      checkOutput("mid_after_frame", last_frame[31:8], 24'h031FFF);
      checkOutput("mid_after_data", rd_last, 8'h81);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
